// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card init sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Drives a byte-level SPI controller via cmd/start; responses arrive as toggle-per-byte.
module sd_init_sequencer #(
    parameter int POWERUP_CYCLES = 80,
    parameter int TIMEOUT_BYTES  = 16,
    parameter int ACMD41_RETRIES = 1000,
    parameter int GAP_CYCLES     = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        begin_i,
    input  logic        responseByte_i,
    input  logic [7:0]  response_i,
    output logic [47:0] cmd_o,
    output logic        start_o,
    output logic        busy_o,
    output logic        ready_o,
    output logic        error_o,
    output logic [2:0]  errorCode_o,
    output logic        cardHC_o
);

    localparam int WAIT_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam int BW = $clog2(TIMEOUT_BYTES + 1);
    localparam int RW = $clog2(ACMD41_RETRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POWERUP, S_SEND, S_WAIT_R1,
        S_READ_TAIL, S_GAP, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [2:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
    } step_t;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] frame(input step_t s);
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [39:0] hdr;
        idx = 6'd0;
        arg = 32'h0;
        unique case (s)
            C_CMD0:   begin idx = 6'd0;  arg = 32'h0;        end
            C_CMD8:   begin idx = 6'd8;  arg = 32'h0000_01AA; end
            C_CMD55:  begin idx = 6'd55; arg = 32'h0;        end
            C_ACMD41: begin idx = 6'd41; arg = 32'h4000_0000; end
            C_CMD58:  begin idx = 6'd58; arg = 32'h0;        end
            default:  begin idx = 6'd0;  arg = 32'h0;        end
        endcase
        hdr = {2'b01, idx, arg};
        return {hdr, crc7(hdr), 1'b1};
    endfunction

    state_t        state_q;
    step_t         step_q;
    logic [47:0]   cmd_q;
    logic          start_q;
    logic          busy_q;
    logic          ready_q;
    logic          error_q;
    logic [2:0]    code_q;
    logic          hc_q;
    logic [WW-1:0] wait_q;
    logic [BW-1:0] bytes_q;
    logic [1:0]    tcnt_q;
    logic [1:0]    send_q;
    logic [23:0]   tail_q;
    logic [7:0]    r1_q;
    logic [RW-1:0] retry_q;
    logic          rb_prev_q;

    logic          byte_ev;
    logic          tail_cmd;
    logic          chk_go;
    logic [BW-1:0] bytes_d;
    logic [31:0]   tail_d;
    logic [47:0]   frame_d;
    logic [7:0]    r1_chk;
    logic          pass_d;
    logic [2:0]    code_d;
    step_t         next_d;
    logic [RW-1:0] retry_d;

    assign byte_ev  = responseByte_i != rb_prev_q;
    assign bytes_d  = bytes_q + 1'b1;
    assign tail_d   = {tail_q, response_i};
    assign frame_d  = frame(step_q);
    assign tail_cmd = (step_q == C_CMD8) || (step_q == C_CMD58);
    assign chk_go   = byte_ev &&
                      (((state_q == S_WAIT_R1) && !response_i[7] && !tail_cmd) ||
                       ((state_q == S_READ_TAIL) && (tcnt_q == 2'd3)));

    // R1 comes live from the bus for short replies, from r1_q once a tail was read
    always_comb begin
        r1_chk  = (state_q == S_WAIT_R1) ? response_i : r1_q;
        pass_d  = 1'b0;
        code_d  = 3'd0;
        next_d  = step_q;
        retry_d = retry_q;
        unique case (step_q)
            C_CMD0: begin
                pass_d = r1_chk == 8'h01;
                code_d = 3'd1;
                next_d = C_CMD8;
            end
            C_CMD8: begin
                pass_d = (r1_chk == 8'h01) && (tail_d[11:0] == 12'h1AA);
                code_d = 3'd2;
                next_d = C_CMD55;
            end
            C_CMD55: begin
                pass_d = (r1_chk == 8'h00) || (r1_chk == 8'h01);
                code_d = 3'd3;
                next_d = C_ACMD41;
            end
            C_ACMD41: begin
                code_d = 3'd3;
                if (r1_chk == 8'h00) begin
                    pass_d = 1'b1;
                    next_d = C_CMD58;
                end else if (r1_chk == 8'h01) begin
                    retry_d = retry_q - 1'b1;
                    pass_d  = retry_d != '0;
                    next_d  = C_CMD55;
                end
            end
            C_CMD58: begin
                pass_d = r1_chk == 8'h00;
                code_d = 3'd4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            step_q    <= C_CMD0;
            cmd_q     <= '1;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= 3'd0;
            hc_q      <= 1'b0;
            wait_q    <= '0;
            bytes_q   <= '0;
            tcnt_q    <= '0;
            send_q    <= '0;
            tail_q    <= '0;
            r1_q      <= '0;
            retry_q   <= '0;
            rb_prev_q <= responseByte_i;
        end else begin
            rb_prev_q <= responseByte_i;
            unique case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (begin_i) begin
                        state_q <= S_POWERUP;
                        step_q  <= C_CMD0;
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        code_q  <= 3'd0;
                        hc_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        retry_q <= RW'(ACMD41_RETRIES);
                        wait_q  <= '0;
                    end
                end
                S_POWERUP: begin
                    if (wait_q == WW'(POWERUP_CYCLES - 1)) begin
                        state_q <= S_SEND;
                        cmd_q   <= frame_d;
                        send_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                // one setup cycle with cmd loaded, then start high for two
                S_SEND: begin
                    send_q <= send_q + 1'b1;
                    if (send_q == 2'd2) begin
                        start_q <= 1'b0;
                        state_q <= S_WAIT_R1;
                        bytes_q <= '0;
                    end else begin
                        start_q <= 1'b1;
                    end
                end
                S_WAIT_R1: begin
                    if (byte_ev) begin
                        bytes_q <= bytes_d;
                        r1_q    <= response_i;
                        if (!response_i[7]) begin
                            if (tail_cmd) begin
                                state_q <= S_READ_TAIL;
                                tcnt_q  <= '0;
                            end
                        end else if (bytes_d == BW'(TIMEOUT_BYTES)) begin
                            state_q <= S_FAIL;
                            error_q <= 1'b1;
                            code_q  <= 3'd5;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_READ_TAIL: begin
                    if (byte_ev) begin
                        tail_q <= tail_d[23:0];
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (wait_q == WW'(GAP_CYCLES - 1)) begin
                        state_q <= S_SEND;
                        cmd_q   <= frame_d;
                        send_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if (chk_go) begin
                retry_q <= retry_d;
                if (!pass_d) begin
                    state_q <= S_FAIL;
                    error_q <= 1'b1;
                    code_q  <= code_d;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end else if (step_q == C_CMD58) begin
                    state_q <= S_DONE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    hc_q    <= tail_d[30];
                end else begin
                    state_q <= S_GAP;
                    wait_q  <= '0;
                    step_q  <= next_d;
                end
            end
        end
    end

    assign cmd_o       = cmd_q;
    assign start_o     = start_q;
    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign error_o     = error_q;
    assign errorCode_o = code_q;
    assign cardHC_o    = hc_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: a scripted card answers each frame.
// Instance 0 uses defaults, instance 1 limits ACMD41 retries to 2.
`timescale 1ns/1ps
module tb_sd_init_sequencer;

    localparam logic [47:0] F_CMD0   = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8   = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD55  = 48'h77_0000_0000_65;
    localparam logic [47:0] F_ACMD41 = 48'h69_4000_0000_77;
    localparam logic [47:0] F_CMD58  = 48'h7A_0000_0000_FD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        beg0, beg1, rb0, rb1;
    logic [7:0]  rsp0, rsp1;
    logic [47:0] cmd0, cmd1;
    logic        st0, st1, busy0, busy1, rdy0, rdy1, err0, err1, hc0, hc1;
    logic [2:0]  code0, code1;

    int sel;
    int n_pass;
    int n_tot;

    logic [47:0] cmd_m;
    logic        st_m, busy_m, rdy_m, err_m, hc_m;
    logic [2:0]  code_m;

    always_comb begin
        cmd_m  = (sel == 0) ? cmd0  : cmd1;
        st_m   = (sel == 0) ? st0   : st1;
        busy_m = (sel == 0) ? busy0 : busy1;
        rdy_m  = (sel == 0) ? rdy0  : rdy1;
        err_m  = (sel == 0) ? err0  : err1;
        hc_m   = (sel == 0) ? hc0   : hc1;
        code_m = (sel == 0) ? code0 : code1;
    end

    sd_init_sequencer u_dut0 (
        .clk_i(clk), .reset_i(reset), .begin_i(beg0),
        .responseByte_i(rb0), .response_i(rsp0),
        .cmd_o(cmd0), .start_o(st0), .busy_o(busy0), .ready_o(rdy0),
        .error_o(err0), .errorCode_o(code0), .cardHC_o(hc0)
    );

    sd_init_sequencer #(.ACMD41_RETRIES(2)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .begin_i(beg1),
        .responseByte_i(rb1), .response_i(rsp1),
        .cmd_o(cmd1), .start_o(st1), .busy_o(busy1), .ready_o(rdy1),
        .error_o(err1), .errorCode_o(code1), .cardHC_o(hc1)
    );

    task automatic send_byte(input logic [7:0] b);
        if (sel == 0) begin
            rsp0 = b;
            rb0  = ~rb0;
        end else begin
            rsp1 = b;
            rb1  = ~rb1;
        end
        @(negedge clk);
    endtask

    task automatic pulse_begin();
        if (sel == 0) beg0 = 1'b1;
        else          beg1 = 1'b1;
        @(negedge clk);
        beg0 = 1'b0;
        beg1 = 1'b0;
    endtask

    task automatic expect_cmd(input logic [47:0] exp, input string nm,
                              output int lows);
        logic [47:0] prev;
        int hi;
        lows = 0;
        prev = cmd_m;
        while (st_m !== 1'b1 && lows < 400) begin
            prev = cmd_m;
            @(negedge clk);
            lows++;
        end
        n_tot++;
        if (st_m !== 1'b1) begin
            $display("FAIL %s_start: no start after %0d cycles", nm, lows);
            return;
        end
        n_pass++;
        n_tot++;
        if (cmd_m !== exp || prev !== exp)
            $display("FAIL %s_frame: got %h (cycle before %h) want %h",
                     nm, cmd_m, prev, exp);
        else
            n_pass++;
        hi = 0;
        while (st_m === 1'b1 && hi < 8) begin
            hi++;
            @(negedge clk);
        end
        n_tot++;
        if (hi != 2)
            $display("FAIL %s_width: start high %0d cycles want 2", nm, hi);
        else
            n_pass++;
    endtask

    task automatic run_to_cmd58();
        int lows;
        pulse_begin();
        expect_cmd(F_CMD0, "p_cmd0", lows);
        send_byte(8'h01);
        expect_cmd(F_CMD8, "p_cmd8", lows);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hAA);
        expect_cmd(F_CMD55, "p_cmd55", lows);
        send_byte(8'h01);
        expect_cmd(F_ACMD41, "p_acmd41", lows);
        send_byte(8'h00);
        expect_cmd(F_CMD58, "p_cmd58", lows);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rb0 = ~rb0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tot++;
        if (cmd0 !== 48'hFFFF_FFFF_FFFF) $display("FAIL rst_cmd: got %h want ffffffffffff", cmd0);
        else n_pass++;
        n_tot++;
        if ({st0, busy0, rdy0, err0, hc0} !== 5'b0)
            $display("FAIL rst_flags: got %b want 00000", {st0, busy0, rdy0, err0, hc0});
        else n_pass++;
        n_tot++;
        if (code0 !== 3'd0) $display("FAIL rst_code: got %0d want 0", code0);
        else n_pass++;
        n_tot++;
        if (cmd1 !== 48'hFFFF_FFFF_FFFF || busy1 !== 1'b0)
            $display("FAIL rst_dut1: got %h/%b want ffffffffffff/0", cmd1, busy1);
        else n_pass++;
    endtask

    task automatic test_full_init();
        int lows;
        sel = 0;
        pulse_begin();
        n_tot++;
        if (busy0 !== 1'b1) $display("FAIL init_busy: got %b want 1", busy0);
        else n_pass++;
        expect_cmd(F_CMD0, "cmd0", lows);
        n_tot++;
        if (lows != 81) $display("FAIL powerup_len: got %0d low cycles want 81", lows);
        else n_pass++;
        send_byte(8'hFF);
        send_byte(8'h01);
        pulse_begin();
        send_byte(8'h00);
        expect_cmd(F_CMD8, "cmd8", lows);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hAA);
        for (int i = 0; i < 4; i++) begin
            expect_cmd(F_CMD55, "cmd55", lows);
            send_byte(8'h01);
            expect_cmd(F_ACMD41, "acmd41", lows);
            send_byte((i < 3) ? 8'h01 : 8'h00);
        end
        expect_cmd(F_CMD58, "cmd58", lows);
        n_tot++;
        if (busy0 !== 1'b1 || rdy0 !== 1'b0)
            $display("FAIL mid_busy: got busy %b ready %b want 1 0", busy0, rdy0);
        else n_pass++;
        send_byte(8'h00); send_byte(8'hC0); send_byte(8'hFF);
        send_byte(8'h80); send_byte(8'h00);
        n_tot++;
        if ({rdy0, hc0, busy0, err0} !== 4'b1100)
            $display("FAIL done_flags: got rdy/hc/busy/err %b want 1100",
                     {rdy0, hc0, busy0, err0});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lows;
        sel = 0;
        pulse_begin();
        n_tot++;
        if ({rdy0, hc0, busy0} !== 3'b001)
            $display("FAIL relaunch_clear: got rdy/hc/busy %b want 001", {rdy0, hc0, busy0});
        else n_pass++;
        expect_cmd(F_CMD0, "to_cmd0", lows);
        repeat (15) send_byte(8'hFF);
        n_tot++;
        if (err0 !== 1'b0 || busy0 !== 1'b1)
            $display("FAIL to_15th: got err %b busy %b want 0 1", err0, busy0);
        else n_pass++;
        send_byte(8'hFF);
        n_tot++;
        if ({err0, busy0, rdy0} !== 3'b100 || code0 !== 3'd5)
            $display("FAIL to_16th: got err/busy/rdy %b code %0d want 100 code 5",
                     {err0, busy0, rdy0}, code0);
        else n_pass++;
    endtask

    task automatic test_r1_last_byte();
        int lows;
        sel = 0;
        pulse_begin();
        expect_cmd(F_CMD0, "lb_cmd0", lows);
        repeat (15) send_byte(8'hFF);
        send_byte(8'h01);
        n_tot++;
        if (err0 !== 1'b0) $display("FAIL lb_accept: got err %b want 0", err0);
        else n_pass++;
        expect_cmd(F_CMD8, "lb_cmd8", lows);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hAB);
        n_tot++;
        if (err0 !== 1'b1 || code0 !== 3'd2)
            $display("FAIL cmd8_bad: got err %b code %0d want 1 code 2", err0, code0);
        else n_pass++;
    endtask

    task automatic test_bad_cmd0();
        int lows;
        sel = 0;
        pulse_begin();
        expect_cmd(F_CMD0, "bad_cmd0", lows);
        send_byte(8'h05);
        n_tot++;
        if (err0 !== 1'b1 || code0 !== 3'd1 || busy0 !== 1'b0)
            $display("FAIL cmd0_bad: got err %b code %0d busy %b want 1 1 0",
                     err0, code0, busy0);
        else n_pass++;
    endtask

    task automatic test_cmd58_bad();
        sel = 0;
        run_to_cmd58();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        n_tot++;
        if (err0 !== 1'b1 || code0 !== 3'd4 || rdy0 !== 1'b0)
            $display("FAIL cmd58_bad: got err %b code %0d rdy %b want 1 4 0",
                     err0, code0, rdy0);
        else n_pass++;
    endtask

    task automatic test_standard_capacity();
        sel = 0;
        run_to_cmd58();
        send_byte(8'h00); send_byte(8'h80); send_byte(8'hFF);
        send_byte(8'h80); send_byte(8'h00);
        n_tot++;
        if ({rdy0, hc0, err0} !== 3'b100)
            $display("FAIL sdsc_flags: got rdy/hc/err %b want 100", {rdy0, hc0, err0});
        else n_pass++;
    endtask

    task automatic test_retries();
        int lows;
        int frames;
        int stray;
        sel = 1;
        pulse_begin();
        expect_cmd(F_CMD0, "rt_cmd0", lows);
        send_byte(8'h01);
        expect_cmd(F_CMD8, "rt_cmd8", lows);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hAA);
        frames = 0;
        for (int i = 0; i < 4 && err_m !== 1'b1; i++) begin
            expect_cmd(F_CMD55, "rt_cmd55", lows);
            send_byte(8'h01);
            expect_cmd(F_ACMD41, "rt_acmd41", lows);
            frames++;
            send_byte(8'h01);
        end
        n_tot++;
        if (frames != 2) $display("FAIL rt_frames: got %0d ACMD41 frames want 2", frames);
        else n_pass++;
        n_tot++;
        if (err_m !== 1'b1 || code_m !== 3'd3 || busy_m !== 1'b0)
            $display("FAIL rt_fail: got err %b code %0d busy %b want 1 3 0",
                     err_m, code_m, busy_m);
        else n_pass++;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (st_m === 1'b1) stray++;
        end
        n_tot++;
        if (stray != 0) $display("FAIL rt_quiet: got %0d start cycles want 0", stray);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lows;
        sel = 0;
        pulse_begin();
        expect_cmd(F_CMD0, "rm_cmd0", lows);
        send_byte(8'hFF);
        reset = 1'b1;
        rb0 = ~rb0;
        @(negedge clk);
        n_tot++;
        if (st0 !== 1'b0 || busy0 !== 1'b0 || cmd0 !== 48'hFFFF_FFFF_FFFF)
            $display("FAIL rm_state: got start %b busy %b cmd %h want 0 0 ffffffffffff",
                     st0, busy0, cmd0);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        pulse_begin();
        expect_cmd(F_CMD0, "rm_restart", lows);
        n_tot++;
        if (lows != 81) $display("FAIL rm_powerup: got %0d low cycles want 81", lows);
        else n_pass++;
        send_byte(8'h01);
        expect_cmd(F_CMD8, "rm_cmd8", lows);
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        sel    = 0;
        reset  = 1'b1;
        beg0   = 1'b0;
        beg1   = 1'b0;
        rb0    = 1'b0;
        rb1    = 1'b0;
        rsp0   = 8'hFF;
        rsp1   = 8'hFF;
        test_reset();
        test_full_init();
        test_timeout();
        test_r1_last_byte();
        test_bad_cmd0();
        test_cmd58_bad();
        test_standard_capacity();
        test_retries();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sd_init_sequencer.md
SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 80: idle clocks after begin before CMD0.
REQ-002 SHALL have parameter TIMEOUT_BYTES, default 16: response bytes counted from a start before R1 timeout.
REQ-003 SHALL have parameter ACMD41_RETRIES, default 1000: max CMD55/ACMD41 pairs.
REQ-004 SHALL have parameter GAP_CYCLES, default 8: idle clocks between a response and the next start.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port begin  in  1  level; sampled high in IDLE/DONE/FAIL launches init.
REQ-008 SHALL have port responseByte  in  1  toggles once per received SPI byte.
REQ-009 SHALL have port response  in  8  byte valid when responseByte toggles.
REQ-010 SHALL have port cmd  out  48  command frame for the SPI controller.
REQ-011 SHALL have port start  out  1  launch strobe; the controller acts on its rising edge.
REQ-012 SHALL have port busy  out  1  high from accepted begin until DONE/FAIL.
REQ-013 SHALL have port ready  out  1  card initialised.
REQ-014 SHALL have port error  out  1  init failed.
REQ-015 SHALL have port errorCode  out  3  failure cause.
REQ-016 SHALL have port cardHC  out  1  OCR CCS bit (high-capacity card).

Function
REQ-017 Frame SHALL be {2'b01, index[5:0], arg[31:0], crc7[6:0], 1'b1}; CRC7 poly x^7+x^3+1, init 0, over the top 40 bits, computed bit-serially or combinationally before start rises.
REQ-018 cmd SHALL be stable from 1 cycle before start rises until the next command is loaded; start SHALL be high exactly 2 cycles per command.
REQ-019 Byte arrival SHALL be detected as responseByte != registered previous value; the previous-value register SHALL be loaded on reset so no spurious byte is seen.
REQ-020 States: IDLE, POWERUP, SEND, WAIT_R1, READ_TAIL, GAP, DONE, FAIL.
REQ-021 IDLE/DONE/FAIL + begin -> POWERUP: clear ready, error, errorCode, cardHC; set busy; load retry counter = ACMD41_RETRIES.
REQ-022 POWERUP SHALL hold start low POWERUP_CYCLES clocks, then SEND CMD0.
REQ-023 SEND -> WAIT_R1 with byte counter cleared; each byte increments it; first byte with bit7 = 0 is R1.
REQ-024 A valid R1 arriving on the byte that makes the count equal TIMEOUT_BYTES SHALL be accepted; the count reaching TIMEOUT_BYTES without R1 -> FAIL, errorCode 5.
REQ-025 CMD8 and CMD58 SHALL go to READ_TAIL and shift the next 4 bytes MSB-first into a 32-bit tail; others go straight to the check.
REQ-026 Sequence/checks: CMD0 arg 0, R1 = 0x01 else code 1; CMD8 arg 0x000001AA, R1 = 0x01 and tail[11:0] = 0x1AA else code 2; CMD55 arg 0, R1 in {0x00, 0x01} else code 3; ACMD41 (index 41) arg 0x40000000; CMD58 arg 0, R1 = 0x00 else code 4.
REQ-027 ACMD41 R1 = 0x00 -> CMD58; R1 = 0x01 -> decrement retries, CMD55 again; retries reaching 0 -> FAIL code 3; any other R1 -> FAIL code 3.
REQ-028 Every passed check SHALL pass through GAP for GAP_CYCLES clocks before the next SEND.
REQ-029 CMD58 pass -> DONE: cardHC = tail[30], ready = 1, busy = 0.
REQ-030 FAIL: error = 1, busy = 0, ready = 0.
REQ-031 begin while busy SHALL be ignored; bytes arriving outside WAIT_R1/READ_TAIL SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE from any state, including mid-command: cmd = 48'hFFFFFFFFFFFF, start = 0, busy = 0, ready = 0, error = 0, errorCode = 0, cardHC = 0, counters 0.

Verification
REQ-033 Reset, begin, card model returns 0x01 -> after 80 idle clocks cmd = 0x400000000095 with start high 2 cycles.
REQ-034 CMD8 reply 0x01,0x00,0x00,0x01,0xAA -> next cmd = 0x48000001AA87 (sent), followed by CMD55 0x770000000065.
REQ-035 ACMD41 returns 0x01 three times then 0x00; CMD58 returns 0x00 + OCR 0xC0FF8000 -> ready = 1, cardHC = 1, busy = 0, error = 0.
REQ-036 Card model returns only 0xFF to CMD0 -> after 16th byte error = 1, errorCode = 5, busy = 0.
REQ-037 ACMD41_RETRIES = 2, ACMD41 always 0x01 -> errorCode = 3 after exactly 2 ACMD41 frames.
REQ-038 Reset asserted in WAIT_R1 -> next cycle start = 0, busy = 0; fresh begin restarts at CMD0.
